// File: rtl/ad1_sample_reader.sv
`default_nettype none
// ============================================================================
// Module      : ad1_sample_reader
// Description : Dual-channel serial ADC reader. A conversion request drops
//               nCS, drives 16 SCLK periods (idle high, falling first),
//               shifts SDATA1/SDATA2 MSB-first on each SCLK rising edge and
//               publishes the low 12 bits of each 16-bit frame with a one-cycle
//               VALID. ERR flags nonzero leading bits [15:12] on either
//               channel. A minimum nCS-high quiet time separates frames.
// Ports       : CLK, RST (async, active-high), START (request),
//               SDATA1/SDATA2 (ADC serial data), nCS, SCLK (ADC control),
//               DATA1/DATA2 (12-bit samples), VALID, ERR, BUSY.
// Revision    : 1.0 - initial release
// ============================================================================
module ad1_sample_reader #(
    parameter int unsigned CLK_DIV = 2,  // CLK cycles per SCLK half-period, 1..255
    parameter int unsigned QUIET   = 4   // min CLK cycles nCS high between frames, 1..255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        SDATA1,
    input  logic        SDATA2,
    output logic        nCS,
    output logic        SCLK,
    output logic [11:0] DATA1,
    output logic [11:0] DATA2,
    output logic        VALID,
    output logic        ERR,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_DONE  = 2'd2,
        S_QUIET = 2'd3
    } state_t;

    localparam logic [7:0] c_div_last   = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_quiet_last = 8'(QUIET - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_sclk;
    logic [7:0]  r_div_cnt;
    logic [4:0]  r_bit_cnt;
    logic [7:0]  r_quiet_cnt;
    logic        r_pending;
    logic [15:0] r_sr1;
    logic [15:0] r_sr2;
    logic [11:0] r_data1;
    logic [11:0] r_data2;
    logic        r_err;

    logic        w_half_done;
    logic        w_last_rise;
    logic        w_quiet_done;
    logic        w_req;
    logic        w_enter_conv;
    logic        w_frame_err;

    assign w_half_done  = (r_div_cnt == c_div_last);
    // The 16th rising edge of SCLK ends the frame on the same CLK edge.
    assign w_last_rise  = (r_state == S_CONV) && w_half_done && !r_sclk &&
                          (r_bit_cnt == 5'd15);
    assign w_quiet_done = (r_quiet_cnt == c_quiet_last);
    assign w_req        = START || r_pending;
    assign w_enter_conv = (w_state_next == S_CONV) && (r_state != S_CONV);
    assign w_frame_err  = (|r_sr1[15:12]) || (|r_sr2[15:12]);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        nCS          = 1'b1;
        BUSY         = 1'b1;
        VALID        = 1'b0;
        case (r_state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (w_req) begin
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                nCS = 1'b0;
                if (w_last_rise) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                VALID        = 1'b1;
                w_state_next = S_QUIET;
            end
            S_QUIET: begin
                // Go straight back to CONV so a waiting request sees exactly
                // DONE + QUIET cycles of nCS high.
                if (w_quiet_done) begin
                    w_state_next = w_req ? S_CONV : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: SCLK generation, shifting, counters, sample registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sclk      <= 1'b1;
            r_div_cnt   <= 8'd0;
            r_bit_cnt   <= 5'd0;
            r_quiet_cnt <= 8'd0;
            r_pending   <= 1'b0;
            r_sr1       <= 16'd0;
            r_sr2       <= 16'd0;
            r_data1     <= 12'd0;
            r_data2     <= 12'd0;
            r_err       <= 1'b0;
        end else begin
            // One-deep request memory; entering CONV consumes it.
            if (w_enter_conv) begin
                r_pending <= 1'b0;
            end else if (START && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end

            if (r_state == S_CONV) begin
                if (w_half_done) begin
                    r_div_cnt <= 8'd0;
                    r_sclk    <= ~r_sclk;
                    if (!r_sclk) begin
                        // SCLK about to rise: capture on this edge.
                        r_sr1     <= {r_sr1[14:0], SDATA1};
                        r_sr2     <= {r_sr2[14:0], SDATA2};
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + 8'd1;
                end
            end else begin
                r_div_cnt <= 8'd0;
                r_sclk    <= 1'b1;
                if (w_enter_conv) begin
                    r_bit_cnt <= 5'd0;
                end
            end

            if ((r_state == S_QUIET) && !w_quiet_done) begin
                r_quiet_cnt <= r_quiet_cnt + 8'd1;
            end else begin
                r_quiet_cnt <= 8'd0;
            end

            if (r_state == S_DONE) begin
                r_data1 <= r_sr1[11:0];
                r_data2 <= r_sr2[11:0];
                r_err   <= w_frame_err;
            end
        end
    end

    // During DONE the fresh frame is presented straight from the shift
    // registers; the held copies take over from the following cycle.
    assign SCLK  = r_sclk;
    assign DATA1 = (r_state == S_DONE) ? r_sr1[11:0] : r_data1;
    assign DATA2 = (r_state == S_DONE) ? r_sr2[11:0] : r_data2;
    assign ERR   = (r_state == S_DONE) ? w_frame_err : r_err;

endmodule
`default_nettype wire

// File: tb/tb_ad1_sample_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad1_sample_reader
// Description : Directed, table-driven bench for ad1_sample_reader with an
//               ADC serial model on each of two instances (CLK_DIV=2 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad1_sample_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: CLK_DIV=2, QUIET=4
    logic        start_a = 1'b0, sd1_a = 1'b0, sd2_a = 1'b0;
    logic        ncs_a, sclk_a, valid_a, err_a, busy_a;
    logic [11:0] d1_a, d2_a;
    // Instance B: CLK_DIV=1, QUIET=4
    logic        start_b = 1'b0, sd1_b = 1'b0, sd2_b = 1'b0;
    logic        ncs_b, sclk_b, valid_b, err_b, busy_b;
    logic [11:0] d1_b, d2_b;

    ad1_sample_reader #(.CLK_DIV(2), .QUIET(4)) u_dut_a (
        .CLK(clk), .RST(rst), .START(start_a), .SDATA1(sd1_a), .SDATA2(sd2_a),
        .nCS(ncs_a), .SCLK(sclk_a), .DATA1(d1_a), .DATA2(d2_a),
        .VALID(valid_a), .ERR(err_a), .BUSY(busy_a)
    );

    ad1_sample_reader #(.CLK_DIV(1), .QUIET(4)) u_dut_b (
        .CLK(clk), .RST(rst), .START(start_b), .SDATA1(sd1_b), .SDATA2(sd2_b),
        .nCS(ncs_b), .SCLK(sclk_b), .DATA1(d1_b), .DATA2(d2_b),
        .VALID(valid_b), .ERR(err_b), .BUSY(busy_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- ADC models: new bit on each SCLK fall ----------------
    logic [15:0] frame1_a = 16'h0, frame2_a = 16'h0;
    logic [15:0] frame1_b = 16'h0, frame2_b = 16'h0;
    int bit_a = 15, bit_b = 15;

    always @(negedge ncs_a) bit_a = 15;
    always @(negedge sclk_a) if (!ncs_a && bit_a >= 0) begin
        sd1_a = frame1_a[bit_a];
        sd2_a = frame2_a[bit_a];
        bit_a = bit_a - 1;
    end
    always @(negedge ncs_b) bit_b = 15;
    always @(negedge sclk_b) if (!ncs_b && bit_b >= 0) begin
        sd1_b = frame1_b[bit_b];
        sd2_b = frame2_b[bit_b];
        bit_b = bit_b - 1;
    end

    // ---------------- Monitors (sample on falling CLK) ----------------
    int low_a = 0, sclk_low_a = 0, rise_a = 0, valid_cnt_a = 0, dbl_a = 0;
    int gap_a = 0, gap_bad_a = 0, falls_a = 0;
    int gaps_a[$];
    logic prev_sclk_a = 1'b1, prev_ncs_a = 1'b1, prev_valid_a = 1'b0;

    always @(negedge clk) begin
        if (!ncs_a) low_a++;
        if (!ncs_a && !sclk_a) sclk_low_a++;
        if (sclk_a && !prev_sclk_a) rise_a++;
        if (valid_a) valid_cnt_a++;
        if (valid_a && prev_valid_a) dbl_a++;
        if (ncs_a) begin
            gap_a++;
            if (!sclk_a) gap_bad_a++;
        end
        if (!ncs_a && prev_ncs_a) begin
            if (falls_a > 0) gaps_a.push_back(gap_a);
            falls_a++;
        end
        if (!ncs_a) gap_a = 0;
        prev_sclk_a  = sclk_a;
        prev_ncs_a   = ncs_a;
        prev_valid_a = valid_a;
    end

    int low_b = 0, sclk_low_b = 0, rise_b = 0, valid_cnt_b = 0, dbl_b = 0;
    logic prev_sclk_b = 1'b1, prev_valid_b = 1'b0;

    always @(negedge clk) begin
        if (!ncs_b) low_b++;
        if (!ncs_b && !sclk_b) sclk_low_b++;
        if (sclk_b && !prev_sclk_b) rise_b++;
        if (valid_b) valid_cnt_b++;
        if (valid_b && prev_valid_b) dbl_b++;
        prev_sclk_b  = sclk_b;
        prev_valid_b = valid_b;
    end

    task automatic clear_a();
        low_a = 0; sclk_low_a = 0; rise_a = 0; valid_cnt_a = 0;
        gap_bad_a = 0; falls_a = 0; gap_a = 0;
        gaps_a.delete();
    endtask

    task automatic wait_idle_a(input string name);
        for (int i = 0; i < 600 && busy_a; i++) tick();
        check(name, busy_a, 1'b0);
    endtask

    // One START pulse, capture outputs in the VALID cycle.
    task automatic frame_a(input logic [15:0] f1, input logic [15:0] f2,
                           output logic [11:0] o1, output logic [11:0] o2,
                           output logic oerr, output bit seen);
        frame1_a = f1;
        frame2_a = f2;
        clear_a();
        o1 = 12'h0; o2 = 12'h0; oerr = 1'b0; seen = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (valid_a) begin
                seen = 1; o1 = d1_a; o2 = d2_a; oerr = err_a;
            end
        end
    endtask

    typedef struct {
        logic [15:0] f1;
        logic [15:0] f2;
        logic [11:0] e1;
        logic [11:0] e2;
        logic        eerr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [11:0] o1, o2;
        logic        oerr;
        bit          seen;

        vecs[0] = '{16'h0ABC, 16'h0123, 12'hABC, 12'h123, 1'b0};
        vecs[1] = '{16'h0ABC, 16'h8123, 12'hABC, 12'h123, 1'b1};
        vecs[2] = '{16'h0555, 16'h0AAA, 12'h555, 12'hAAA, 1'b0};
        vecs[3] = '{16'h1000, 16'h0000, 12'h000, 12'h000, 1'b1};
        vecs[4] = '{16'h0FFF, 16'h0FFF, 12'hFFF, 12'hFFF, 1'b0};
        vecs[5] = '{16'hF000, 16'h7FFF, 12'h000, 12'hFFF, 1'b1};

        // ---- Reset state ----
        start_a = 1'b1;  // must be ignored while in reset
        tick(); tick(); tick();
        check("reset_outputs_a",
              {3'b0, ncs_a, sclk_a, d1_a, d2_a, valid_a, err_a, busy_a},
              {3'b0, 1'b1, 1'b1, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0});
        check("reset_outputs_b",
              {3'b0, ncs_b, sclk_b, d1_b, d2_b, valid_b, err_b, busy_b},
              {3'b0, 1'b1, 1'b1, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0});
        start_a = 1'b0;
        rst = 1'b0;
        clear_a();
        for (int i = 0; i < 10; i++) tick();
        check("no_conv_without_start", falls_a, 0);

        // ---- Table-driven frames ----
        foreach (vecs[i]) begin
            frame_a(vecs[i].f1, vecs[i].f2, o1, o2, oerr, seen);
            check($sformatf("vec%0d_valid_seen", i), seen, 1'b1);
            check($sformatf("vec%0d_data1", i), o1, vecs[i].e1);
            check($sformatf("vec%0d_data2", i), o2, vecs[i].e2);
            check($sformatf("vec%0d_err", i), oerr, vecs[i].eerr);
            wait_idle_a($sformatf("vec%0d_idle", i));
            check($sformatf("vec%0d_ncs_low_cycles", i), low_a, 64);
            check($sformatf("vec%0d_sclk_rises", i), rise_a, 16);
            check($sformatf("vec%0d_sclk_low_cycles", i), sclk_low_a, 32);
            check($sformatf("vec%0d_valid_pulses", i), valid_cnt_a, 1);
            check($sformatf("vec%0d_data1_held", i), d1_a, vecs[i].e1);
            check($sformatf("vec%0d_err_held", i), err_a, vecs[i].eerr);
        end

        // ---- START held for three frames ----
        frame1_a = 16'h0ABC; frame2_a = 16'h0123;
        clear_a();
        start_a = 1'b1;
        for (int i = 0; i < 600 && falls_a < 3; i++) tick();
        start_a = 1'b0;
        check("held_third_frame_started", falls_a, 3);
        wait_idle_a("held_idle");
        for (int i = 0; i < 10; i++) tick();
        check("held_valid_pulses", valid_cnt_a, 3);
        check("held_gap_count", gaps_a.size(), 2);
        foreach (gaps_a[i]) check($sformatf("held_gap%0d", i), gaps_a[i], 5);
        check("held_sclk_high_in_gaps", gap_bad_a, 0);

        // ---- Pending request: two STARTs in CONV, one in QUIET ----
        clear_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (valid_a) seen = 1;
        end
        check("pend_first_valid", seen, 1'b1);
        tick();  // first QUIET cycle
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_idle_a("pend_idle");
        for (int i = 0; i < 20; i++) tick();
        check("pend_valid_pulses", valid_cnt_a, 2);
        check("pend_frames", falls_a, 2);
        check("pend_gap_count", gaps_a.size(), 1);
        foreach (gaps_a[i]) check("pend_gap_immediate", gaps_a[i], 5);

        // ---- Reset at the 7th SCLK rising edge ----
        frame1_a = 16'h0ABC; frame2_a = 16'h0123;
        clear_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 0; i < 200 && rise_a < 7; i++) tick();
        check("abort_reached_rise7", rise_a, 7);
        rst = 1'b1;
        #1;
        check("abort_immediate_outputs",
              {ncs_a, sclk_a, valid_a, busy_a}, {1'b1, 1'b1, 1'b0, 1'b0});
        check("abort_data_cleared", {8'h0, d1_a, d2_a}, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("abort_no_valid", valid_cnt_a, 0);
        check("abort_stays_idle", {ncs_a, busy_a}, {1'b1, 1'b0});
        frame_a(16'h0ABC, 16'h0123, o1, o2, oerr, seen);
        check("after_abort_valid", seen, 1'b1);
        check("after_abort_data", {7'h0, oerr, o1, o2}, {7'h0, 1'b0, 12'hABC, 12'h123});
        wait_idle_a("after_abort_idle");
        check("after_abort_ncs_low_cycles", low_a, 64);

        // ---- CLK_DIV=1 instance ----
        frame1_b = 16'h0FFF; frame2_b = 16'h0000;
        low_b = 0; sclk_low_b = 0; rise_b = 0; valid_cnt_b = 0;
        start_b = 1'b1; tick(); start_b = 1'b0;
        seen = 0; o1 = 12'h0; o2 = 12'h0; oerr = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (valid_b) begin
                seen = 1; o1 = d1_b; o2 = d2_b; oerr = err_b;
            end
        end
        check("div1_valid_seen", seen, 1'b1);
        check("div1_data1", o1, 12'hFFF);
        check("div1_data2", o2, 12'h000);
        check("div1_err", oerr, 1'b0);
        for (int i = 0; i < 200 && busy_b; i++) tick();
        check("div1_idle", busy_b, 1'b0);
        check("div1_ncs_low_cycles", low_b, 32);
        check("div1_sclk_rises", rise_b, 16);
        check("div1_sclk_low_cycles", sclk_low_b, 16);

        check("valid_never_double_a", dbl_a, 0);
        check("valid_never_double_b", dbl_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
